// File: rtl/dense_layer_pkg.sv
// rtl/dense_layer_pkg.sv - shared types and constants for the dense-layer run controller
package dense_layer_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        RUN    = 2'd2,
        DONE   = 2'd3
    } run_state_e;

    localparam int TS_W_DEFAULT = 64;

    // Result reported to software when the watchdog aborts a run
    localparam logic [31:0] Y0_TIMEOUT = 32'h0;

endpackage

// File: rtl/dense_layer_cycle_timer.sv
// rtl/dense_layer_cycle_timer.sv - free-running cycle counter, cleared only by the global reset
module dense_layer_cycle_timer #(
    parameter int TS_W = 64
) (
    input  logic            clk,
    input  logic            rst,
    output logic [TS_W-1:0] count
);

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else begin
            count <= count + TS_W'(1);
        end
    end

endmodule

// File: rtl/dense_layer_run_ctrl.sv
// rtl/dense_layer_run_ctrl.sv - launches the dense-layer core, timestamps the run and guards it with a watchdog
module dense_layer_run_ctrl
    import dense_layer_pkg::*;
#(
    parameter int          TS_W           = TS_W_DEFAULT,
    parameter logic [31:0] TIMEOUT_CYCLES = 32'hFFFF_FFFF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            debug_rst_local,
    output logic            core_start,
    output logic            core_rst,
    input  logic            core_done,
    input  logic [31:0]     core_y0,
    output logic [31:0]     output_y0,
    output logic [31:0]     debug_counter,
    output logic [TS_W-1:0] start_time,
    output logic [TS_W-1:0] end_time,
    output logic            all_done,
    output logic            timed_out
);

    logic [TS_W-1:0] cycle_cnt;
    run_state_e      state;
    logic            start_q;
    logic            start_rise;
    logic [32:0]     count_inc;
    logic [31:0]     count_sat;
    logic            wd_fire;

    dense_layer_cycle_timer #(
        .TS_W (TS_W)
    ) u_timer (
        .clk   (clk),
        .rst   (rst),
        .count (cycle_cnt)
    );

    assign start_rise = start & ~start_q;
    assign core_start = (state == LAUNCH);

    // The 33-bit sum doubles as the saturation detector and the watchdog compare
    assign count_inc = {1'b0, debug_counter} + 33'd1;
    assign count_sat = count_inc[32] ? debug_counter : count_inc[31:0];
    assign wd_fire   = (state == RUN) && !core_done && (TIMEOUT_CYCLES != 32'd0) &&
                       (count_inc == {1'b0, TIMEOUT_CYCLES});

    always_ff @(posedge clk) begin
        if (rst || debug_rst_local) begin
            state         <= IDLE;
            start_q       <= 1'b0;
            output_y0     <= '0;
            debug_counter <= '0;
            start_time    <= '0;
            end_time      <= '0;
            all_done      <= 1'b0;
            timed_out     <= 1'b0;
        end else begin
            start_q <= start;
            case (state)
                IDLE: begin
                    if (start_rise) begin
                        state <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    start_time    <= cycle_cnt;
                    debug_counter <= '0;
                    state         <= RUN;
                end
                RUN: begin
                    debug_counter <= count_sat;
                    if (core_done) begin
                        end_time  <= cycle_cnt;
                        output_y0 <= core_y0;
                        all_done  <= 1'b1;
                        state     <= DONE;
                    end else if (wd_fire) begin
                        end_time  <= cycle_cnt;
                        output_y0 <= Y0_TIMEOUT;
                        timed_out <= 1'b1;
                        all_done  <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    // Results stay readable until software deliberately relaunches
                    if (start_rise) begin
                        all_done  <= 1'b0;
                        timed_out <= 1'b0;
                        state     <= LAUNCH;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        core_rst <= rst | debug_rst_local | wd_fire;
    end

endmodule

// File: tb/tb_dense_layer_run_ctrl.sv
// tb/tb_dense_layer_run_ctrl.sv - scoreboard bench for dense_layer_run_ctrl
module tb_dense_layer_run_ctrl;

    typedef struct packed {
        logic [31:0] y;
        logic [31:0] dc;
        logic [63:0] st;
        logic [63:0] et;
        logic        to;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        start_a = 0, dbg_a = 0, done_a = 0;
    logic [31:0] y_a = 0;
    logic        core_start_a, core_rst_a, all_done_a, timed_out_a;
    logic [31:0] output_y0_a, debug_counter_a;
    logic [63:0] start_time_a, end_time_a;

    logic        start_b = 0, dbg_b = 0, done_b = 0;
    logic [31:0] y_b = 0;
    logic        core_start_b, core_rst_b, all_done_b, timed_out_b;
    logic [31:0] output_y0_b, debug_counter_b;
    logic [3:0]  start_time_b, end_time_b;

    dense_layer_run_ctrl dut_a (
        .clk(clk), .rst(rst), .start(start_a), .debug_rst_local(dbg_a),
        .core_start(core_start_a), .core_rst(core_rst_a), .core_done(done_a), .core_y0(y_a),
        .output_y0(output_y0_a), .debug_counter(debug_counter_a),
        .start_time(start_time_a), .end_time(end_time_a),
        .all_done(all_done_a), .timed_out(timed_out_a)
    );

    dense_layer_run_ctrl #(.TS_W(4), .TIMEOUT_CYCLES(32'd8)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .debug_rst_local(dbg_b),
        .core_start(core_start_b), .core_rst(core_rst_b), .core_done(done_b), .core_y0(y_b),
        .output_y0(output_y0_b), .debug_counter(debug_counter_b),
        .start_time(start_time_b), .end_time(end_time_b),
        .all_done(all_done_b), .timed_out(timed_out_b)
    );

    int total = 0;
    int bad = 0;
    exp_t qa[$];
    exp_t qb[$];
    int cs_cnt_a = 0;
    logic ad_prev_a = 0, ad_prev_b = 0;
    logic [63:0] tb_cnt = 0;
    exp_t ea, eb;

    always @(posedge clk) tb_cnt <= rst ? 64'd0 : tb_cnt + 64'd1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic exp_t mk(input logic [31:0] y, input logic [31:0] dc,
                                input logic [63:0] st, input logic [63:0] et, input logic to);
        exp_t e;
        e.y = y; e.dc = dc; e.st = st; e.et = et; e.to = to;
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input logic [63:0] n);
        int guard = 0;
        while (tb_cnt != n && guard < 2000) begin
            tick();
            guard++;
        end
        if (guard >= 2000) check("wait_bound", tb_cnt, n);
    endtask

    // Completion monitors: every rising all_done consumes one scoreboard entry
    always @(negedge clk) begin
        if (core_start_a) cs_cnt_a <= cs_cnt_a + 1;
        ad_prev_a <= all_done_a;
        if (all_done_a && !ad_prev_a) begin
            if (qa.size() == 0) begin
                check("a_unexpected_done", 64'd1, 64'd0);
            end else begin
                ea = qa.pop_front();
                check("a_y0", output_y0_a, ea.y);
                check("a_dbg_cnt", debug_counter_a, ea.dc);
                check("a_start_time", start_time_a, ea.st);
                check("a_end_time", end_time_a, ea.et);
                check("a_timed_out", timed_out_a, ea.to);
            end
        end
    end

    always @(negedge clk) begin
        ad_prev_b <= all_done_b;
        if (all_done_b && !ad_prev_b) begin
            if (qb.size() == 0) begin
                check("b_unexpected_done", 64'd1, 64'd0);
            end else begin
                eb = qb.pop_front();
                check("b_y0", output_y0_b, eb.y);
                check("b_dbg_cnt", debug_counter_b, eb.dc);
                check("b_start_time", start_time_b, eb.st);
                check("b_end_time", end_time_b, eb.et);
                check("b_timed_out", timed_out_b, eb.to);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL time_limit: got timeout want finish");
        $fatal(1, "time limit");
    end

    initial begin
        int cs0;
        repeat (3) tick();
        check("rst_core_rst", core_rst_a, 1);
        check("rst_core_start", core_start_a, 0);
        check("rst_all_done", all_done_a, 0);
        rst = 0;

        // Normal run: launch at 11, done at 36
        wait_until(10); start_a = 1;
        tick(); check("launch_pulse", core_start_a, 1);
        tick(); check("launch_one_cycle", core_start_a, 0);
        check("start_time_11", start_time_a, 64'd11);
        wait_until(36); done_a = 1; y_a = 32'hFFFF_FFF9;
        qa.push_back(mk(32'hFFFF_FFF9, 32'd25, 64'd11, 64'd36, 1'b0));
        tick(); done_a = 0;

        // Held start never relaunches; a new edge does
        wait_until(50);
        check("no_relaunch", cs_cnt_a, 1);
        check("y0_stable", output_y0_a, 32'hFFFF_FFF9);
        start_a = 0;
        wait_until(52); start_a = 1;
        tick(); check("relaunch_pulse", core_start_a, 1);
        check("all_done_cleared", all_done_a, 0);
        done_a = 1; y_a = 32'd99;
        tick(); done_a = 0;
        check("launch_done_ignored", all_done_a, 0);
        check("start_time_53", start_time_a, 64'd53);
        check("end_time_stable", end_time_a, 64'd36);
        wait_until(60); done_a = 1; y_a = 32'd123;
        qa.push_back(mk(32'd123, 32'd7, 64'd53, 64'd60, 1'b0));
        tick(); done_a = 0;

        // Soft reset five cycles into RUN
        wait_until(62); start_a = 0;
        wait_until(64); start_a = 1;
        wait_until(70); dbg_a = 1;
        tick();
        check("srst_all_done", all_done_a, 0);
        check("srst_y0", output_y0_a, 0);
        check("srst_dbg_cnt", debug_counter_a, 0);
        check("srst_start_time", start_time_a, 0);
        check("srst_end_time", end_time_a, 0);
        check("srst_core_rst", core_rst_a, 1);
        check("srst_idle", core_start_a, 0);
        tick();
        check("srst_dominates_start", core_start_a, 0);
        dbg_a = 0; start_a = 0;
        tick();
        check("srst_core_rst_release", core_rst_a, 0);
        done_a = 1; y_a = 32'd55;
        tick(); done_a = 0;
        check("idle_done_ignored", all_done_a, 0);
        check("idle_done_y0", output_y0_a, 0);
        wait_until(76); start_a = 1;
        tick(); check("post_srst_launch", core_start_a, 1);
        tick(); check("post_srst_start_time", start_time_a, 64'd77);
        wait_until(80); done_a = 1; y_a = 32'hFFFF_FFFF;
        qa.push_back(mk(32'hFFFF_FFFF, 32'd3, 64'd77, 64'd80, 1'b0));
        tick(); done_a = 0;

        // 4-bit timestamps: launch at 93 (=13 mod 16), done 6 cycles later wraps
        wait_until(92); start_b = 1;
        tick(); check("b_launch_pulse", core_start_b, 1);
        wait_until(99); done_b = 1; y_b = 32'h1234;
        qb.push_back(mk(32'h1234, 32'd6, 64'd13, 64'd3, 1'b0));
        tick(); done_b = 0; start_b = 0;

        // Watchdog at 8 RUN cycles
        wait_until(102); start_b = 1;
        qb.push_back(mk(32'd0, 32'd8, 64'd7, 64'd15, 1'b1));
        wait_until(111); check("wd_core_rst_pre", core_rst_b, 0);
        tick(); check("wd_core_rst_pulse", core_rst_b, 1);
        tick(); check("wd_core_rst_post", core_rst_b, 0);
        wait_until(114); start_b = 0;
        wait_until(116); start_b = 1;
        wait_until(125); done_b = 1; y_b = 32'hFFFF_FF9C;
        qb.push_back(mk(32'hFFFF_FF9C, 32'd8, 64'd5, 64'd13, 1'b0));
        tick(); done_b = 0;
        check("tie_no_core_rst", core_rst_b, 0);

        // Start held high across reset
        wait_until(130);
        start_b = 0; rst = 1;
        repeat (3) tick();
        check("rst2_y0_a", output_y0_a, 0);
        check("rst2_all_done_a", all_done_a, 0);
        check("rst2_end_time_a", end_time_a, 0);
        check("rst2_dbg_cnt_a", debug_counter_a, 0);
        check("rst2_y0_b", output_y0_b, 0);
        check("rst2_core_rst_b", core_rst_b, 1);
        cs0 = cs_cnt_a;
        rst = 0;
        tick(); check("held_start_launch", core_start_a, 1);
        tick(); check("held_start_one_cycle", core_start_a, 0);
        check("held_start_time", start_time_a, 64'd1);
        repeat (5) tick();
        check("held_start_single", cs_cnt_a - cs0, 1);

        check("qa_drained", qa.size(), 0);
        check("qb_drained", qb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
